// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - clipped rectangle fill streaming palette indices into the framebuffer
// Define FB_WRITER_BLANK_GATE_EN to add wr_allow, which stalls FILL while low.
module fb_rect_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [8:0]        cmd_y0,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
`ifdef FB_WRITER_BLANK_GATE_EN
  input  logic              wr_allow,
`endif
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, FINISH} stateT;

  stateT state, stateNext;

  logic [9:0]        x0Lat, wLat, wc, col;
  logic [8:0]        y0Lat, hLat, hc, row;
  logic [DATA_W-1:0] colorLat;
  logic [ADDR_W-1:0] rowBase, startAddr;
  logic [10:0]       xSpan;
  logic [9:0]        ySpan;
  logic [9:0]        wcCalc;
  logic [8:0]        hcCalc;
  logic              offScreen, emptyRect;
  logic              wrenReg, pixelStep, lastCol, lastRow;

  // Clip arithmetic only matters when the origin is on-screen; otherwise SETUP goes to FINISH.
  always_comb begin
    offScreen = (32'(x0Lat) >= 32'(H_RES)) || (32'(y0Lat) >= 32'(V_RES));
    emptyRect = (wLat == '0) || (hLat == '0);
    xSpan     = 11'(H_RES) - {1'b0, x0Lat};
    ySpan     = 10'(V_RES) - {1'b0, y0Lat};
    wcCalc    = ({1'b0, wLat} < xSpan) ? wLat : xSpan[9:0];
    hcCalc    = ({1'b0, hLat} < ySpan) ? hLat : ySpan[8:0];
    startAddr = ADDR_W'(y0Lat) * ADDR_W'(H_RES) + ADDR_W'(x0Lat);
  end

`ifdef FB_WRITER_BLANK_GATE_EN
  assign pixelStep = (state == FILL) && wr_allow;
  assign fb_wren   = wrenReg && wr_allow;
`else
  assign pixelStep = (state == FILL);
  assign fb_wren   = wrenReg;
`endif

  assign lastCol = (col == wc - 10'd1);
  assign lastRow = (row == hc - 9'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) stateNext = SETUP;
      SETUP:   stateNext = (offScreen || emptyRect) ? FINISH : FILL;
      FILL:    if (pixelStep && lastCol && lastRow) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wrenReg   <= 1'b0;
      x0Lat     <= '0;
      y0Lat     <= '0;
      wLat      <= '0;
      hLat      <= '0;
      colorLat  <= '0;
      wc        <= '0;
      hc        <= '0;
      col       <= '0;
      row       <= '0;
      rowBase   <= '0;
      fb_addr   <= '0;
      fb_data   <= '0;
    end else begin
      cmd_ready <= (stateNext == IDLE);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == FINISH);
      err       <= (state == SETUP) && offScreen;
      wrenReg   <= (stateNext == FILL);

      if (state == IDLE && cmd_valid && cmd_ready) begin
        x0Lat    <= cmd_x0;
        y0Lat    <= cmd_y0;
        wLat     <= cmd_w;
        hLat     <= cmd_h;
        colorLat <= cmd_color;
      end

      if (state == SETUP) begin
        wc      <= wcCalc;
        hc      <= hcCalc;
        col     <= '0;
        row     <= '0;
        rowBase <= startAddr;
        fb_addr <= startAddr;
        fb_data <= colorLat;
      end

      // The final pixel leaves the address untouched so it never steps past the last line.
      if (pixelStep) begin
        if (lastCol) begin
          if (!lastRow) begin
            col     <= '0;
            row     <= row + 9'd1;
            rowBase <= rowBase + ADDR_W'(H_RES);
            fb_addr <= rowBase + ADDR_W'(H_RES);
          end
        end else begin
          col     <= col + 10'd1;
          fb_addr <= fb_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
